// File: rtl/button_conditioner.sv
// Five-button front end: synchronize, debounce, auto-repeat, and align the
// resulting press/repeat events to the game clock as one-period strobes.
module button_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         REPEAT_DELAY    = 50000000,
  parameter int         REPEAT_RATE     = 15000000,
  parameter logic [4:0] REPEAT_MASK     = 5'b01111
) (
  input  logic       full_clock,
  input  logic       Reset,
  input  logic [4:0] btn_raw,
  input  logic       game_clk,
  output logic [4:0] btn_pulse,
  output logic [4:0] btn_level
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } state_t;

  logic [4:0]    raw_s1, raw_s2;
  logic          gclk_s1, gclk_s2, gclk_prev;
  logic          gclk_fall;
  logic [CW-1:0] db_cnt  [5];
  logic [CW-1:0] rep_cnt [5];
  state_t        btn_state [5];
  state_t        btn_state_nxt [5];
  logic [4:0]    evt, rep_clr, rep_inc;
  logic [4:0]    pending;

  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      raw_s1    <= '0;
      raw_s2    <= '0;
      gclk_s1   <= 1'b0;
      gclk_s2   <= 1'b0;
      gclk_prev <= 1'b0;
    end else begin
      raw_s1    <= btn_raw;
      raw_s2    <= raw_s1;
      gclk_s1   <= game_clk;
      gclk_s2   <= gclk_s1;
      gclk_prev <= gclk_s2;
    end
  end

  assign gclk_fall = gclk_prev & ~gclk_s2;

  // Counter runs only while the input disagrees with the debounced level.
  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      btn_level <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (raw_s2[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]    <= '0;
          btn_level[i] <= ~btn_level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 5; i++) btn_state[i] <= IDLE;
    end else begin
      for (int i = 0; i < 5; i++) btn_state[i] <= btn_state_nxt[i];
    end
  end

  // The state itself remembers the level, so IDLE with level high is the rising edge.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      btn_state_nxt[i] = btn_state[i];
      case (btn_state[i])
        IDLE:        if (btn_level[i]) btn_state_nxt[i] = HELD_DELAY;
        HELD_DELAY:  if (!btn_level[i]) btn_state_nxt[i] = IDLE;
                     else if (REPEAT_MASK[i] && rep_cnt[i] == RD_LAST) btn_state_nxt[i] = HELD_REPEAT;
        HELD_REPEAT: if (!btn_level[i]) btn_state_nxt[i] = IDLE;
        default:     btn_state_nxt[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    evt     = '0;
    rep_clr = '0;
    rep_inc = '0;
    for (int i = 0; i < 5; i++) begin
      case (btn_state[i])
        IDLE: begin
          if (btn_level[i]) begin
            evt[i]     = 1'b1;
            rep_clr[i] = 1'b1;
          end
        end
        HELD_DELAY: begin
          if (btn_level[i] && REPEAT_MASK[i]) begin
            if (rep_cnt[i] == RD_LAST) begin
              evt[i]     = 1'b1;
              rep_clr[i] = 1'b1;
            end else begin
              rep_inc[i] = 1'b1;
            end
          end
        end
        HELD_REPEAT: begin
          if (btn_level[i]) begin
            if (rep_cnt[i] == RR_LAST) begin
              evt[i]     = 1'b1;
              rep_clr[i] = 1'b1;
            end else begin
              rep_inc[i] = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 5; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (rep_clr[i])      rep_cnt[i] <= '0;
        else if (rep_inc[i]) rep_cnt[i] <= rep_cnt[i] + CW'(1);
      end
    end
  end

  // An event landing on the falling-edge cycle survives into the next window.
  always_ff @(posedge full_clock or posedge Reset) begin
    if (Reset) begin
      pending   <= '0;
      btn_pulse <= '0;
    end else if (gclk_fall) begin
      btn_pulse <= pending;
      pending   <= evt;
    end else begin
      pending   <= pending | evt;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected strobes go into a queue and a
// monitor compares them against btn_pulse at each game_clk rising edge.
module tb_button_conditioner;

  logic       full_clock = 1'b0;
  logic       Reset      = 1'b1;
  logic [4:0] btn_raw    = '0;
  logic       game_clk;
  logic [4:0] btn_pulse;
  logic [4:0] btn_level;

  logic [2:0] gdiv      = '0;
  logic       gclk_hold = 1'b0;

  logic [4:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY   (40),
    .REPEAT_RATE    (16),
    .REPEAT_MASK    (5'b01111)
  ) dut (
    .full_clock(full_clock),
    .Reset     (Reset),
    .btn_raw   (btn_raw),
    .game_clk  (game_clk),
    .btn_pulse (btn_pulse),
    .btn_level (btn_level)
  );

  // Clock / reset block; game_clk is full_clock / 8 and can be frozen.
  always #5 full_clock = ~full_clock;

  always @(posedge full_clock) begin
    if (!gclk_hold) gdiv <= gdiv + 3'd1;
  end
  assign game_clk = gdiv[2];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge full_clock);
    #1;
  endtask

  task automatic wait_level(input int idx, input logic val, input int budget, input string name);
    int k;
    k = 0;
    while (btn_level[idx] !== val && k < budget) begin
      cyc(1);
      k++;
    end
    check(name, {31'd0, btn_level[idx]}, {31'd0, val});
  endtask

  // Scoreboard monitor
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge game_clk);
      @(negedge full_clock);
      if (btn_pulse != 5'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {27'd0, btn_pulse}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse", {27'd0, btn_pulse}, {27'd0, e});
        end
      end
    end
  end

  initial begin
    int k;
    int w;

    // Reset state
    cyc(3);
    check("reset_pulse", {27'd0, btn_pulse}, 32'd0);
    check("reset_level", {27'd0, btn_level}, 32'd0);
    Reset = 1'b0;
    cyc(5);

    // Glitch on C shorter than debounce
    btn_raw[4] = 1'b1;
    cyc(3);
    btn_raw[4] = 1'b0;
    cyc(20);
    check("glitch_level", {27'd0, btn_level}, 32'd0);

    // Single press on L: latency and pulse width
    exp_q.push_back(5'b00001);
    btn_raw[0] = 1'b1;
    cyc(9);
    check("latency_9", {31'd0, btn_level[0]}, 32'd0);
    cyc(1);
    check("latency_10", {31'd0, btn_level[0]}, 32'd1);
    k = 0;
    while (btn_pulse[0] !== 1'b1 && k < 40) begin
      cyc(1);
      k++;
    end
    check("pulse0_seen", {31'd0, btn_pulse[0]}, 32'd1);
    w = 0;
    while (btn_pulse[0] === 1'b1 && w < 20) begin
      cyc(1);
      w++;
    end
    check("pulse0_width", w, 8);
    btn_raw[0] = 1'b0;
    wait_level(0, 1'b0, 30, "l_release");
    cyc(30);

    // Auto-repeat on U: press + 5 repeats
    repeat (6) exp_q.push_back(5'b00010);
    btn_raw[1] = 1'b1;
    wait_level(1, 1'b1, 40, "u_press");
    cyc(104);
    btn_raw[1] = 1'b0;
    wait_level(1, 1'b0, 30, "u_release");
    cyc(40);

    // C is masked: one pulse only
    exp_q.push_back(5'b10000);
    btn_raw[4] = 1'b1;
    wait_level(4, 1'b1, 40, "c_press");
    cyc(104);
    btn_raw[4] = 1'b0;
    wait_level(4, 1'b0, 30, "c_release");
    cyc(40);

    // Two R presses with no game_clk falling edge between: coalesced
    exp_q.push_back(5'b01000);
    gclk_hold = 1'b1;
    for (int p = 0; p < 2; p++) begin
      btn_raw[3] = 1'b1;
      wait_level(3, 1'b1, 40, "r_press");
      cyc(4);
      btn_raw[3] = 1'b0;
      wait_level(3, 1'b0, 30, "r_release");
      cyc(4);
    end
    check("r_no_pulse_frozen", {27'd0, btn_pulse}, 32'd0);
    gclk_hold = 1'b0;
    cyc(40);

    // L and R on the same cycle
    exp_q.push_back(5'b01001);
    btn_raw = 5'b01001;
    wait_level(0, 1'b1, 40, "lr_press");
    check("lr_level", {27'd0, btn_level}, 32'h09);
    cyc(10);
    btn_raw = 5'b00000;
    wait_level(0, 1'b0, 30, "lr_release");
    cyc(30);

    // Reset while D is pending, D still held afterwards
    gclk_hold = 1'b1;
    btn_raw[2] = 1'b1;
    wait_level(2, 1'b1, 40, "d_press");
    cyc(3);
    Reset = 1'b1;
    #1;
    check("midreset_pulse", {27'd0, btn_pulse}, 32'd0);
    check("midreset_level", {27'd0, btn_level}, 32'd0);
    cyc(2);
    exp_q.push_back(5'b00100);
    Reset = 1'b0;
    gclk_hold = 1'b0;
    cyc(9);
    check("redebounce_9", {31'd0, btn_level[2]}, 32'd0);
    cyc(1);
    check("redebounce_10", {31'd0, btn_level[2]}, 32'd1);
    cyc(20);
    btn_raw[2] = 1'b0;
    wait_level(2, 1'b0, 30, "d_release");
    cyc(50);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
